cyc_stim_gen: RTL and testbench
===============================

CYC_STIM_GEN -- requirements
Module: cyc_stim_gen

Interface
REQ-001 Parameter WIDTH, default 32, width of the cycle count.
REQ-002 Parameter LAST_CYC, default 99, count value at which the run terminates; must be >0 and <2**WIDTH-1.
REQ-003 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port en  input  1  run enable; high starts or continues counting.
REQ-006 Port cyc  output  WIDTH  registered cycle count presented downstream.
REQ-007 Port cyc_opaque  output  WIDTH  separately registered copy of cyc; must not be merged with cyc.
REQ-008 Port valid  output  1  cyc/cyc_opaque hold a new value for downstream.
REQ-009 Port ready  input  1  downstream accepts the current value.
REQ-010 Port obs_x  input  2  downstream observed split-driven vector {x1,x0}.
REQ-011 Port obs_y  input  2  downstream observed separately driven pair {y1,y0}.
REQ-012 Port err  output  1  sticky mismatch flag.
REQ-013 Port err_count  output  8  saturating mismatch count (see Configuration).
REQ-014 Port done  output  1  run finished; sticky until reset.

Function
REQ-015 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-016 IDLE -> RUN on the edge where en=1; otherwise stay in IDLE; cyc is held.
REQ-017 valid=1 only in RUN; it is a combinational decode of the state register.
REQ-018 In RUN, a handshake (valid&&ready) increments cyc and cyc_opaque by 1, both becoming visible at the same edge; if ready=0, both hold.
REQ-019 Check on every handshake, in the same edge: mismatch if obs_x!=obs_y, or obs_x[0]!=cyc[0], or obs_x[1]!=cyc[0].
REQ-020 A mismatch sets err at that edge; err stays set until rst.
REQ-021 RUN -> DONE at the edge where a handshake makes cyc equal LAST_CYC; done=1 from that edge; no further increments.
REQ-022 RUN with en=0 -> IDLE, with cyc retained; a later en=1 resumes from the retained value.
REQ-023 A handshake coinciding with en=0 still increments and checks, then enters IDLE.
REQ-024 A handshake coinciding with reaching LAST_CYC while en=0 goes to DONE; DONE has priority over IDLE.
REQ-025 DONE ignores en, ready and the obs inputs.
REQ-026 Arithmetic is modulo 2**WIDTH; because of the LAST_CYC bound, no wrap occurs in normal operation.
REQ-027 A mismatch comparison uses the pre-increment cyc value.

Reset
REQ-028 rst=1 at a clock edge forces state=IDLE, cyc=0, cyc_opaque=0, err=0, err_count=0, done=0, including mid-RUN and in DONE.
REQ-029 rst has priority over every other event in the same cycle.

Configuration
REQ-030 Macro CYC_STIM_ERRCNT_EN defined: err_count increments by 1 per mismatch and saturates at 8'hFF.
REQ-031 Macro CYC_STIM_ERRCNT_EN undefined: err_count is tied to 0 and no counter flops exist; err behaves identically.

Structure
REQ-032 Package cyc_stim_pkg holds the state enum typedef (IDLE/RUN/DONE) and the ERRCNT_W=8 constant.
REQ-033 Sub-module cyc_stim_chk holds the comparison of REQ-019 plus err/err_count; cyc_stim_gen instantiates it once.

Verification
REQ-034 Reset, en=1, ready=1, obs driven consistently -> cyc reaches 99 after exactly 99 handshakes, done=1, err=0.
REQ-035 ready low for cycles 10..14 while cyc=10 -> cyc holds 10, and cyc_opaque==cyc every cycle.
REQ-036 At cyc=5, obs_y=2'b10 while obs_x=2'b11 -> err=1 from the next edge, err_count=1 with the macro and 0 without; the run continues.
REQ-037 en dropped at cyc=20 with ready=1 -> cyc=21 and the FSM is in IDLE; en raised 3 cycles later -> resumes at 21.
REQ-038 rst pulsed at cyc=40 with err=1 -> all outputs 0 and IDLE next edge; a fresh run completes at 99.
REQ-039 With the macro defined, 300 forced mismatches -> err_count=8'hFF, holding there.

Source files
------------

// File: rtl/cyc_stim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cyc_stim_pkg
// Brief    : Shared state encoding and error-counter width for cyc_stim_gen.
// Revision : 1.0 - initial release
// ============================================================================
package cyc_stim_pkg;

    localparam int ERRCNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cyc_stim_chk.sv
`default_nettype none
// ============================================================================
// Module   : cyc_stim_chk
// Brief    : Observed-vector consistency check with sticky err and optional
//            saturating mismatch counter (macro CYC_STIM_ERRCNT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module cyc_stim_chk
    import cyc_stim_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                hs,
    input  logic                cyc_lsb,
    input  logic [1:0]          obs_x,
    input  logic [1:0]          obs_y,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_count
);

    logic w_mismatch;
    logic r_err;

    // Both halves of the split vector must track the pre-increment count LSB.
    assign w_mismatch = (obs_x != obs_y) || (obs_x[0] != cyc_lsb) || (obs_x[1] != cyc_lsb);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (hs && w_mismatch) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

`ifdef CYC_STIM_ERRCNT_EN
    logic [ERRCNT_W-1:0] r_err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (hs && w_mismatch && (r_err_count != {ERRCNT_W{1'b1}})) begin
            r_err_count <= r_err_count + ERRCNT_W'(1);
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/cyc_stim_gen.sv
`default_nettype none
// ============================================================================
// Module   : cyc_stim_gen
// Brief    : Handshaked cycle-count stimulus generator, IDLE/RUN/DONE control
//            with observed-vector checking (optional macro CYC_STIM_ERRCNT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module cyc_stim_gen
    import cyc_stim_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int LAST_CYC = 99
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic [WIDTH-1:0]    cyc,
    output logic [WIDTH-1:0]    cyc_opaque,
    output logic                valid,
    input  logic                ready,
    input  logic [1:0]          obs_x,
    input  logic [1:0]          obs_y,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_count,
    output logic                done
);

    localparam logic [WIDTH-1:0] c_LAST_CYC = WIDTH'(LAST_CYC);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cyc;
    (* keep = "true" *) logic [WIDTH-1:0] r_cyc_opaque;
    logic [WIDTH-1:0] w_cyc_inc;
    logic             w_hs;

    assign w_hs      = (r_state == RUN) && ready;
    assign w_cyc_inc = r_cyc + WIDTH'(1);

    // Reaching the last count wins over a simultaneous drop of en.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (en) w_state_nxt = RUN;
            RUN: begin
                if (w_hs && (w_cyc_inc == c_LAST_CYC)) w_state_nxt = DONE;
                else if (!en)                          w_state_nxt = IDLE;
            end
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst)       r_cyc <= '0;
        else if (w_hs) r_cyc <= w_cyc_inc;
    end

    // Independent copy with its own incrementer so it stays a distinct register.
    always_ff @(posedge clk) begin
        if (rst)       r_cyc_opaque <= '0;
        else if (w_hs) r_cyc_opaque <= r_cyc_opaque + WIDTH'(1);
    end

    assign cyc        = r_cyc;
    assign cyc_opaque = r_cyc_opaque;
    assign valid      = (r_state == RUN);
    assign done       = (r_state == DONE);

    cyc_stim_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .hs        (w_hs),
        .cyc_lsb   (r_cyc[0]),
        .obs_x     (obs_x),
        .obs_y     (obs_y),
        .err       (err),
        .err_count (err_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_cyc_stim_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_cyc_stim_gen
// Brief    : Randomized self-checking bench for cyc_stim_gen against a
//            behavioural run/pause/finish model (honours CYC_STIM_ERRCNT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cyc_stim_gen;

    localparam int LAST      = 99;
    localparam int LONG_LAST = 1000;

    logic        clk = 1'b0;
    logic        rst, en, ready;
    logic [1:0]  obs_x, obs_y;
    logic [31:0] cyc, cyc_opaque;
    logic        valid, err, done;
    logic [7:0]  err_count;
    logic [15:0] l_cyc, l_cyc_opaque;
    logic        l_valid, l_err, l_done;
    logic [7:0]  l_err_count;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model of the main instance
    int unsigned m_cyc;
    bit          m_run, m_done, m_err;
    int          m_errcnt;

    always #5 clk = ~clk;

    cyc_stim_gen #(.WIDTH(32), .LAST_CYC(LAST)) u_dut (
        .clk(clk), .rst(rst), .en(en), .cyc(cyc), .cyc_opaque(cyc_opaque),
        .valid(valid), .ready(ready), .obs_x(obs_x), .obs_y(obs_y),
        .err(err), .err_count(err_count), .done(done)
    );

    // Long-running instance so hundreds of handshakes fit in one run.
    cyc_stim_gen #(.WIDTH(16), .LAST_CYC(LONG_LAST)) u_dut_long (
        .clk(clk), .rst(rst), .en(en), .cyc(l_cyc), .cyc_opaque(l_cyc_opaque),
        .valid(l_valid), .ready(ready), .obs_x(obs_x), .obs_y(obs_y),
        .err(l_err), .err_count(l_err_count), .done(l_done)
    );

    function automatic int exp_cnt(input int n);
`ifdef CYC_STIM_ERRCNT_EN
        return (n > 255) ? 255 : n;
`else
        return 0;
`endif
    endfunction

    // One clock edge; advance the model with the inputs the DUT sampled.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_cyc = 0; m_run = 0; m_done = 0; m_err = 0; m_errcnt = 0;
        end else if (m_run) begin
            if (ready) begin
                if ((obs_x != obs_y) || (obs_x != {2{m_cyc[0]}})) begin
                    m_err = 1;
`ifdef CYC_STIM_ERRCNT_EN
                    if (m_errcnt < 255) m_errcnt++;
`endif
                end
                m_cyc++;
                if (m_cyc == LAST) begin m_done = 1; m_run = 0; end
                else if (!en)      m_run = 0;
            end else if (!en) begin
                m_run = 0;
            end
        end else if (!m_done && en) begin
            m_run = 1;
        end
        #1;
    endtask

    task automatic set_obs_ok();
        obs_x = {2{m_cyc[0]}};
        obs_y = obs_x;
    endtask

    task automatic do_reset();
        rst = 1; en = 0; ready = 0; obs_x = 0; obs_y = 0;
        tick();
        rst = 0;
    endtask

    task automatic run_to(input int target);
        en = 1; ready = 1;
        for (int i = 0; i < 300 && !(m_cyc == target && m_run); i++) begin
            set_obs_ok();
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        n_vec++; if (cyc !== 32'd0)        begin n_err++; $display("FAIL reset cyc: got %0d want 0", cyc); end
        n_vec++; if (cyc_opaque !== 32'd0) begin n_err++; $display("FAIL reset cyc_opaque: got %0d want 0", cyc_opaque); end
        n_vec++; if (valid !== 1'b0)       begin n_err++; $display("FAIL reset valid: got %b want 0", valid); end
        n_vec++; if (done !== 1'b0)        begin n_err++; $display("FAIL reset done: got %b want 0", done); end
        n_vec++; if (err !== 1'b0)         begin n_err++; $display("FAIL reset err: got %b want 0", err); end
        n_vec++; if (err_count !== 8'd0)   begin n_err++; $display("FAIL reset err_count: got %0d want 0", err_count); end
    endtask

    task automatic test_full_run();
        int dut_hs = 0;
        do_reset();
        en = 1; ready = 1;
        for (int i = 0; i < 250 && !m_done; i++) begin
            set_obs_ok();
            if (valid && ready) dut_hs++;
            tick();
            n_vec++; if (cyc !== m_cyc)        begin n_err++; $display("FAIL full_run cyc: got %0d want %0d", cyc, m_cyc); end
            n_vec++; if (cyc_opaque !== m_cyc) begin n_err++; $display("FAIL full_run cyc_opaque: got %0d want %0d", cyc_opaque, m_cyc); end
        end
        n_vec++; if (dut_hs != LAST)  begin n_err++; $display("FAIL full_run handshakes: got %0d want %0d", dut_hs, LAST); end
        n_vec++; if (cyc !== 32'(LAST)) begin n_err++; $display("FAIL full_run final cyc: got %0d want %0d", cyc, LAST); end
        n_vec++; if (done !== 1'b1)   begin n_err++; $display("FAIL full_run done: got %b want 1", done); end
        n_vec++; if (err !== 1'b0)    begin n_err++; $display("FAIL full_run err: got %b want 0", err); end
        // DONE ignores everything
        for (int i = 0; i < 20; i++) begin
            en = 1'($urandom); ready = 1'($urandom); obs_x = 2'($urandom); obs_y = 2'($urandom);
            tick();
            n_vec++; if (cyc !== 32'(LAST)) begin n_err++; $display("FAIL done_hold cyc: got %0d want %0d", cyc, LAST); end
            n_vec++; if ({done, valid, err} !== 3'b100) begin n_err++; $display("FAIL done_hold flags done/valid/err: got %b want 100", {done, valid, err}); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        run_to(10);
        ready = 0;
        for (int i = 0; i < 5; i++) begin
            set_obs_ok();
            tick();
            n_vec++; if (cyc !== 32'd10)     begin n_err++; $display("FAIL stall cyc: got %0d want 10", cyc); end
            n_vec++; if (cyc_opaque !== cyc) begin n_err++; $display("FAIL stall cyc_opaque: got %0d want %0d", cyc_opaque, cyc); end
        end
        for (int i = 0; i < 600 && !m_done; i++) begin
            ready = 1'($urandom); set_obs_ok();
            tick();
            n_vec++; if (cyc !== m_cyc)      begin n_err++; $display("FAIL stall_rand cyc: got %0d want %0d", cyc, m_cyc); end
            n_vec++; if (cyc_opaque !== cyc) begin n_err++; $display("FAIL stall_rand cyc_opaque: got %0d want %0d", cyc_opaque, cyc); end
            n_vec++; if (valid !== m_run)    begin n_err++; $display("FAIL stall_rand valid: got %b want %b", valid, m_run); end
        end
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL stall_rand done: got %b want 1", done); end
    endtask

    task automatic test_mismatch();
        do_reset();
        run_to(5);
        obs_x = 2'b11; obs_y = 2'b10; ready = 1;
        tick();
        n_vec++; if (err !== 1'b1)                  begin n_err++; $display("FAIL mismatch err: got %b want 1", err); end
        n_vec++; if (err_count !== 8'(exp_cnt(1)))  begin n_err++; $display("FAIL mismatch err_count: got %0d want %0d", err_count, exp_cnt(1)); end
        n_vec++; if (cyc !== 32'd6)                 begin n_err++; $display("FAIL mismatch cyc: got %0d want 6", cyc); end
        for (int i = 0; i < 10; i++) begin set_obs_ok(); tick(); end
        n_vec++; if (err !== 1'b1)                  begin n_err++; $display("FAIL mismatch sticky err: got %b want 1", err); end
        n_vec++; if (err_count !== 8'(exp_cnt(1)))  begin n_err++; $display("FAIL mismatch sticky err_count: got %0d want %0d", err_count, exp_cnt(1)); end
        n_vec++; if (cyc !== 32'd16)                begin n_err++; $display("FAIL mismatch continue cyc: got %0d want 16", cyc); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            en    = ($urandom_range(0, 7) != 0);
            ready = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin obs_x = 2'($urandom); obs_y = 2'($urandom); end
            else set_obs_ok();
            tick();
            n_vec++; if (cyc !== m_cyc)            begin n_err++; $display("FAIL random cyc: got %0d want %0d", cyc, m_cyc); end
            n_vec++; if ({valid, done} !== {m_run, m_done}) begin n_err++; $display("FAIL random valid/done: got %b want %b", {valid, done}, {m_run, m_done}); end
            n_vec++; if (err !== m_err)            begin n_err++; $display("FAIL random err: got %b want %b", err, m_err); end
            n_vec++; if (err_count !== 8'(m_errcnt)) begin n_err++; $display("FAIL random err_count: got %0d want %0d", err_count, m_errcnt); end
        end
        rst = 0;
    endtask

    task automatic test_pause();
        do_reset();
        run_to(20);
        en = 0; ready = 1; set_obs_ok();
        tick();
        n_vec++; if (cyc !== 32'd21)  begin n_err++; $display("FAIL pause cyc: got %0d want 21", cyc); end
        n_vec++; if (valid !== 1'b0)  begin n_err++; $display("FAIL pause valid: got %b want 0", valid); end
        for (int i = 0; i < 3; i++) begin set_obs_ok(); tick(); end
        n_vec++; if (cyc !== 32'd21)  begin n_err++; $display("FAIL pause hold cyc: got %0d want 21", cyc); end
        n_vec++; if ({valid, done} !== 2'b00) begin n_err++; $display("FAIL pause hold valid/done: got %b want 00", {valid, done}); end
        en = 1;
        tick();
        n_vec++; if ({valid, cyc} !== {1'b1, 32'd21}) begin n_err++; $display("FAIL resume valid/cyc: got %b/%0d want 1/21", valid, cyc); end
        set_obs_ok();
        tick();
        n_vec++; if (cyc !== 32'd22)  begin n_err++; $display("FAIL resume cyc: got %0d want 22", cyc); end
        run_to(LAST - 1);
        en = 0; ready = 1; set_obs_ok();
        tick();
        n_vec++; if ({done, valid} !== 2'b10) begin n_err++; $display("FAIL last_en0 done/valid: got %b want 10", {done, valid}); end
        n_vec++; if (cyc !== 32'(LAST))       begin n_err++; $display("FAIL last_en0 cyc: got %0d want %0d", cyc, LAST); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_to(3);
        obs_x = 2'b01; obs_y = 2'b01;
        tick();
        run_to(40);
        n_vec++; if ({err, cyc} !== {1'b1, 32'd40}) begin n_err++; $display("FAIL reset_mid pre err/cyc: got %b/%0d want 1/40", err, cyc); end
        rst = 1; en = 1; ready = 1;
        tick();
        rst = 0;
        n_vec++; if ({cyc, cyc_opaque} !== 64'd0) begin n_err++; $display("FAIL reset_mid cyc/opaque: got %0d/%0d want 0/0", cyc, cyc_opaque); end
        n_vec++; if ({valid, done, err, err_count} !== 11'd0) begin n_err++; $display("FAIL reset_mid flags: got %b want 0", {valid, done, err, err_count}); end
        for (int i = 0; i < 250 && !m_done; i++) begin set_obs_ok(); tick(); end
        n_vec++; if ({done, err, cyc} !== {1'b1, 1'b0, 32'(LAST)}) begin n_err++; $display("FAIL reset_mid rerun done/err/cyc: got %b/%b/%0d want 1/0/%0d", done, err, cyc, LAST); end
        rst = 1;
        tick();
        rst = 0;
        n_vec++; if ({done, cyc} !== 33'd0) begin n_err++; $display("FAIL reset_in_done done/cyc: got %b/%0d want 0/0", done, cyc); end
    endtask

    task automatic test_saturate();
        do_reset();
        en = 1; ready = 1; obs_x = 2'b01; obs_y = 2'b10;
        for (int k = 1; k <= 320; k++) begin
            tick();
            n_vec++; if (l_err_count !== 8'(exp_cnt(k - 1))) begin n_err++; $display("FAIL saturate err_count at %0d: got %0d want %0d", k, l_err_count, exp_cnt(k - 1)); end
        end
        n_vec++; if (l_err !== 1'b1) begin n_err++; $display("FAIL saturate err: got %b want 1", l_err); end
        n_vec++; if (err_count !== 8'(m_errcnt)) begin n_err++; $display("FAIL saturate main err_count: got %0d want %0d", err_count, m_errcnt); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_cyc = 0; m_run = 0; m_done = 0; m_err = 0; m_errcnt = 0;
        rst = 1; en = 0; ready = 0; obs_x = 0; obs_y = 0;
        test_reset();
        test_full_run();
        test_stall();
        test_mismatch();
        test_pause();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
